frame_source_arbiter: RTL and testbench

FRAME_SOURCE_ARBITER -- requirements
Module: frame_source_arbiter

---
 rtl/frame_source_arbiter.sv | 156 +++++++++++++++
 tb/tb_frame_source_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_source_arbiter.sv
`default_nettype none
// ============================================================================
// frame_source_arbiter
// Grants one of two pixel sources exclusive access to the SDRAM write path
// for a whole frame. A frame ends when all pixels are written, or it is
// abandoned after too many idle cycles.
// Rev 1.0 - initial release
// ============================================================================
module frame_source_arbiter #(
  parameter int H_DISP      = 640,
  parameter int V_DISP      = 480,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdram_ready,
  input  logic [1:0]  mode,
  input  logic        src0_req,
  input  logic        src1_req,
  input  logic        src0_we,
  input  logic        src1_we,
  input  logic [23:0] src0_data,
  input  logic [23:0] src1_data,
  output logic        src0_gnt,
  output logic        src1_gnt,
  output logic [23:0] sys_data,
  output logic        sys_we,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_abort,
  output logic        active_src
);

  localparam int             TCW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [18:0]    PIX_LAST = 19'(H_DISP * V_DISP - 1);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t         state, next_state;
  logic           sel;
  logic           last_src;
  logic [18:0]    pix_cnt;
  logic [TCW-1:0] tmo_cnt;

  logic elig, pick;
  logic start_go, accept, last_px, tmo_hit;

  // Source selection for the next frame; only consulted while idle
  always_comb begin
    elig = 1'b0;
    pick = 1'b0;
    case (mode)
      2'b00: begin
        elig = src0_req;
        pick = 1'b0;
      end
      2'b01: begin
        elig = src1_req;
        pick = 1'b1;
      end
      2'b10: begin
        // prefer the source that did not complete the previous frame
        if (last_src ? src0_req : src1_req) begin
          elig = 1'b1;
          pick = ~last_src;
        end else if (last_src ? src1_req : src0_req) begin
          elig = 1'b1;
          pick = last_src;
        end
      end
      default: begin
        if (src1_req) begin
          elig = 1'b1;
          pick = 1'b1;
        end else if (src0_req) begin
          elig = 1'b1;
          pick = 1'b0;
        end
      end
    endcase
  end

  // Next-state logic, grants and per-cycle frame events
  always_comb begin
    next_state = state;
    src0_gnt   = (state == S_STREAM) && !sel && sdram_ready;
    src1_gnt   = (state == S_STREAM) &&  sel && sdram_ready;
    start_go   = 1'b0;
    accept     = sel ? (src1_we & src1_gnt) : (src0_we & src0_gnt);
    last_px    = accept && (pix_cnt == PIX_LAST);
    tmo_hit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (sdram_ready && elig) begin
          start_go   = 1'b1;
          next_state = S_STREAM;
        end
      end
      S_STREAM: begin
        // an accepted write always beats an expiring timeout
        tmo_hit = !accept && sdram_ready && (tmo_cnt == TMO_LAST);
        if (last_px)      next_state = S_DONE;
        else if (tmo_hit) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Datapath: selection, counters, registered write port and event pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel         <= 1'b0;
      active_src  <= 1'b0;
      last_src    <= 1'b1;
      pix_cnt     <= '0;
      tmo_cnt     <= '0;
      sys_we      <= 1'b0;
      sys_data    <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_start <= start_go;
      frame_done  <= last_px;
      frame_abort <= tmo_hit;
      sys_we      <= accept;
      if (accept) sys_data <= sel ? src1_data : src0_data;
      if (start_go) begin
        sel        <= pick;
        active_src <= pick;
        pix_cnt    <= '0;
        tmo_cnt    <= '0;
      end else if (accept) begin
        pix_cnt <= pix_cnt + 19'd1;
        tmo_cnt <= '0;
      end else if (state == S_STREAM && sdram_ready) begin
        tmo_cnt <= tmo_cnt + TCW'(1);
      end
      // an aborted frame leaves last_src untouched
      if (state == S_DONE) last_src <= sel;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_source_arbiter.sv
`default_nettype none
// ============================================================================
// tb_frame_source_arbiter
// Scenario bench for frame_source_arbiter against a frame-level reference.
// Rev 1.0 - initial release
// ============================================================================
module tb_frame_source_arbiter;

  localparam int H = 16, V = 6, TMO = 100;
  localparam int TOTAL = H * V;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sdram_ready = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        src0_req = 0, src1_req = 0, src0_we = 0, src1_we = 0;
  logic [23:0] src0_data = '0, src1_data = '0;
  logic        src0_gnt, src1_gnt, sys_we, frame_start, frame_done, frame_abort, active_src;
  logic [23:0] sys_data;

  int n_checks = 0;
  int n_fail   = 0;

  frame_source_arbiter #(.H_DISP(H), .V_DISP(V), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .sdram_ready(sdram_ready), .mode(mode),
    .src0_req(src0_req), .src1_req(src1_req), .src0_we(src0_we), .src1_we(src1_we),
    .src0_data(src0_data), .src1_data(src1_data),
    .src0_gnt(src0_gnt), .src1_gnt(src1_gnt), .sys_data(sys_data), .sys_we(sys_we),
    .frame_start(frame_start), .frame_done(frame_done), .frame_abort(frame_abort),
    .active_src(active_src)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (frame-level bookkeeping) --------------
  int          m_phase;     // 0 waiting for a frame, 1 frame open, 2 frame just completed
  int          m_owner, m_written, m_idle, m_last;
  logic        e_we, e_start, e_done, e_abort, e_active;
  logic [23:0] e_data;

  function automatic void model_reset();
    m_phase = 0; m_owner = 0; m_written = 0; m_idle = 0; m_last = 1;
    e_we = 0; e_start = 0; e_done = 0; e_abort = 0; e_active = 0; e_data = '0;
  endfunction

  function automatic int model_pick();
    logic r [2];
    int   pref;
    r[0] = src0_req; r[1] = src1_req;
    case (mode)
      2'b00:   return r[0] ? 0 : -1;
      2'b01:   return r[1] ? 1 : -1;
      2'b10: begin
        pref = 1 - m_last;
        if (r[pref])     return pref;
        if (r[1 - pref]) return 1 - pref;
        return -1;
      end
      default: return r[1] ? 1 : (r[0] ? 0 : -1);
    endcase
  endfunction

  // Called at each rising edge with the inputs that were stable in that cycle
  function automatic void model_edge();
    logic        w [2];
    logic [23:0] d [2];
    int          p;
    w[0] = src0_we; w[1] = src1_we; d[0] = src0_data; d[1] = src1_data;
    e_we = 0; e_start = 0; e_done = 0; e_abort = 0;
    if (m_phase == 0) begin
      p = model_pick();
      if (sdram_ready && p >= 0) begin
        m_owner = p; m_phase = 1; m_written = 0; m_idle = 0;
        e_start = 1; e_active = p[0];
      end
    end else if (m_phase == 1) begin
      if (sdram_ready && w[m_owner]) begin
        e_we = 1; e_data = d[m_owner];
        m_written++; m_idle = 0;
        if (m_written == TOTAL) begin m_phase = 2; e_done = 1; end
      end else if (sdram_ready) begin
        m_idle++;
        if (m_idle == TMO) begin m_phase = 0; e_abort = 1; end
      end
    end else begin
      m_last  = m_owner;
      m_phase = 0;
    end
  endfunction

  function automatic logic [30:0] exp_vec();
    logic g0, g1;
    g0 = (m_phase == 1) && (m_owner == 0) && sdram_ready;
    g1 = (m_phase == 1) && (m_owner == 1) && sdram_ready;
    return {g0, g1, e_we, e_data, e_start, e_done, e_abort, e_active};
  endfunction

  function automatic logic [30:0] obs();
    return {src0_gnt, src1_gnt, sys_we, sys_data, frame_start, frame_done, frame_abort, active_src};
  endfunction

  task automatic do_reset();
    rst = 1; sdram_ready = 0; src0_req = 0; src1_req = 0; src0_we = 0; src1_we = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
  endtask

  // ---------------- scenarios ----------------------------------------------
  task automatic test_reset();
    model_reset();
    #1;
    n_checks++;
    if (obs() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", obs(), exp_vec());
    end
    do_reset();
    @(negedge clk);
    n_checks++;
    if (obs() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_idle: got %h want %h", obs(), exp_vec());
    end
    @(posedge clk); model_edge(); #1;
  endtask

  task automatic test_force_src0();
    int n_start = 0, n_we = 0, n_done = 0, last_we_cyc = -1, done_cyc = -2;
    do_reset();
    mode = 2'b00; sdram_ready = 1; src0_req = 1; src0_we = 1; src1_req = 1; src1_we = 1;
    for (int i = 0; i < 115; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("FAIL force0_cyc%0d: got %h want %h", i, obs(), exp_vec());
      end
      if (frame_start) n_start++;
      if (sys_we) begin n_we++; last_we_cyc = i; end
      if (frame_done) begin n_done++; done_cyc = i; end
      @(posedge clk); model_edge(); #1;
      if (m_phase == 1) src0_req = 0;
      src0_data = $urandom; src1_data = $urandom;
    end
    n_checks++; if (n_start !== 1) begin n_fail++; $display("FAIL force0_starts: got %0d want 1", n_start); end
    n_checks++; if (n_we !== TOTAL) begin n_fail++; $display("FAIL force0_writes: got %0d want %0d", n_we, TOTAL); end
    n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL force0_done: got %0d want 1", n_done); end
    n_checks++; if (done_cyc !== last_we_cyc) begin n_fail++; $display("FAIL force0_done_time: got %0d want %0d", done_cyc, last_we_cyc); end
  endtask

  task automatic test_alternate();
    int owners [$];
    int want [4] = '{0, 1, 0, 1};
    do_reset();
    mode = 2'b10; sdram_ready = 1; src0_req = 1; src1_req = 1;
    for (int i = 0; i < 900 && owners.size() < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("FAIL alt_cyc%0d: got %h want %h", i, obs(), exp_vec());
      end
      if (frame_start) owners.push_back(int'(active_src));
      @(posedge clk); model_edge(); #1;
      src0_we = ($urandom_range(3) != 0); src1_we = ($urandom_range(3) != 0);
      src0_data = $urandom; src1_data = $urandom;
    end
    n_checks++;
    if (owners.size() !== 4) begin
      n_fail++; $display("FAIL alt_frames: got %0d want 4", owners.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (owners[k] !== want[k]) begin
          n_fail++; $display("FAIL alt_owner%0d: got %0d want %0d", k, owners[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_priority();
    int owners [$];
    int we_before = 0;
    do_reset();
    mode = 2'b11; sdram_ready = 1; src0_req = 1; src1_req = 0; src0_we = 1; src1_we = 1;
    for (int i = 0; i < 400 && owners.size() < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("FAIL prio_cyc%0d: got %h want %h", i, obs(), exp_vec());
      end
      if (frame_start) owners.push_back(int'(active_src));
      if (sys_we && owners.size() == 1) we_before++;
      @(posedge clk); model_edge(); #1;
      if (i == 40) src1_req = 1;
      if (i > 60) src0_req = 0;
      src0_data = $urandom; src1_data = $urandom;
    end
    n_checks++;
    if (owners.size() != 2 || owners[0] != 0 || owners[1] != 1) begin
      n_fail++; $display("FAIL prio_order: got %0d frames, first %0d second %0d want 0 then 1",
                         owners.size(), (owners.size() > 0) ? owners[0] : -1,
                         (owners.size() > 1) ? owners[1] : -1);
    end
    n_checks++;
    if (we_before !== TOTAL) begin
      n_fail++; $display("FAIL prio_src0_pixels: got %0d want %0d", we_before, TOTAL);
    end
  endtask

  task automatic test_ready_drop();
    int n_we = 0, n_abort = 0, n_done = 0, drop_left = 0, gnt_during_drop = 0;
    do_reset();
    mode = 2'b00; sdram_ready = 1; src0_req = 1; src0_we = 1;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("FAIL drop_cyc%0d: got %h want %h", i, obs(), exp_vec());
      end
      if (sys_we) n_we++;
      if (frame_abort) n_abort++;
      if (frame_done) n_done++;
      if (drop_left > 0 && (src0_gnt || src1_gnt)) gnt_during_drop++;
      @(posedge clk); model_edge(); #1;
      if (m_phase == 1) src0_req = 0;
      if (drop_left > 0) drop_left--;
      else if (m_written == 30 && n_done == 0 && sdram_ready) drop_left = 50;
      sdram_ready = (drop_left == 0);
      src0_data = $urandom;
    end
    n_checks++; if (n_abort !== 0) begin n_fail++; $display("FAIL drop_abort: got %0d want 0", n_abort); end
    n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL drop_done: got %0d want 1", n_done); end
    n_checks++; if (n_we !== TOTAL) begin n_fail++; $display("FAIL drop_writes: got %0d want %0d", n_we, TOTAL); end
    n_checks++; if (gnt_during_drop !== 0) begin n_fail++; $display("FAIL drop_gnt: got %0d want 0", gnt_during_drop); end
  endtask

  task automatic test_timeout();
    int last_we_cyc = -1, abort_cyc = -1, n_done = 0, n_abort = 0, restart = 0;
    do_reset();
    mode = 2'b00; sdram_ready = 1; src0_req = 1; src0_we = 1;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("FAIL tmo_cyc%0d: got %h want %h", i, obs(), exp_vec());
      end
      if (sys_we) last_we_cyc = i;
      if (frame_done) n_done++;
      if (frame_abort) begin n_abort++; abort_cyc = i; end
      if (frame_start && abort_cyc >= 0) restart++;
      @(posedge clk); model_edge(); #1;
      src0_we = (m_written < 10) && (abort_cyc < 0);
      src0_data = $urandom;
    end
    n_checks++; if (n_abort !== 1) begin n_fail++; $display("FAIL tmo_abort_count: got %0d want 1", n_abort); end
    n_checks++; if (abort_cyc - last_we_cyc !== TMO) begin n_fail++; $display("FAIL tmo_delay: got %0d want %0d", abort_cyc - last_we_cyc, TMO); end
    n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL tmo_done: got %0d want 0", n_done); end
    n_checks++; if (restart !== 1) begin n_fail++; $display("FAIL tmo_regrant: got %0d want 1", restart); end
  endtask

  task automatic test_reset_mid();
    int first_owner = -1, n_pulse = 0;
    do_reset();
    mode = 2'b10; sdram_ready = 1; src0_req = 1; src1_req = 1; src0_we = 1; src1_we = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      @(posedge clk); model_edge(); #1;
      src0_data = $urandom; src1_data = $urandom;
    end
    #2 rst = 1;
    #1;
    n_checks++;
    if (obs() !== 31'd0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %h want 0", obs());
    end
    model_reset();
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("FAIL rstmid_cyc%0d: got %h want %h", i, obs(), exp_vec());
      end
      if (frame_start && first_owner < 0) first_owner = int'(active_src);
      if (frame_done || frame_abort) n_pulse++;
      @(posedge clk); model_edge(); #1;
    end
    n_checks++; if (first_owner !== 0) begin n_fail++; $display("FAIL rstmid_first_grant: got %0d want 0", first_owner); end
    n_checks++; if (n_pulse !== 0) begin n_fail++; $display("FAIL rstmid_pulses: got %0d want 0", n_pulse); end
  endtask

  task automatic test_random();
    int n_frames = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(19) == 0) src0_req = ~src0_req;
      if ($urandom_range(19) == 0) src1_req = ~src1_req;
      src0_we = ($urandom_range(9) < 7); src1_we = ($urandom_range(9) < 7);
      sdram_ready = ($urandom_range(9) != 0);
      src0_data = $urandom; src1_data = $urandom;
      @(negedge clk);
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("FAIL rand_cyc%0d: got %h want %h", i, obs(), exp_vec());
      end
      if (frame_done) n_frames++;
      @(posedge clk); model_edge(); #1;
    end
    n_checks++; if (n_frames < 3) begin n_fail++; $display("FAIL rand_progress: got %0d frames want >=3", n_frames); end
  endtask

  initial begin
    test_reset();
    test_force_src0();
    test_alternate();
    test_priority();
    test_ready_drop();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
